pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV64 core.
- Generates the PC update enable and select, plus per-stage enable/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Inputs it arbitrates: ibus/dbus wait states, load-use hazards and execute-stage redirects.
- Owns the fetch-drop state machine. An ibus request must be held stable until data_ok, so a redirect during an in-flight fetch is deferred and the stale response is discarded.

Parameters:
- ADDR_W, 64, width of PC and redirect target.
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ireq_valid  in  1  core is issuing a fetch (tied 1 today)
- iresp_data_ok  in  1  fetch response valid this cycle
- dreq_valid  in  1  MEM stage has an active dbus request
- dresp_data_ok  in  1  dbus response valid this cycle
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_is_load  in  1  EX instruction is a load
- ex_dst  in  REG_W  EX destination register
- id_ra1, id_ra2  in  REG_W  decode source registers
- id_use1, id_use2  in  1  decode actually reads ra1/ra2
- ex_redirect  in  1  EX resolved a taken branch/jump
- ex_target  in  ADDR_W  redirect target
- pc_we  out  1  PC register update enable
- pc_sel  out  1  0 = pc+4, 1 = pc_target
- pc_target  out  ADDR_W  redirect PC to load
- fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush  out  1 each  pipeline register controls; flush loads a bubble when en=1
- stall_cnt  out  32  cycles with pc_we=0, for debug

Behaviour:
- Reset: state F_NORM, pend_pc=0, stall_cnt=0.
  - While reset is high: all *_en=1, all *_flush=1, pc_we=0, pc_sel=0, pc_target=0.
- Derived signals:
  - mstall = dreq_valid & ~dresp_data_ok
  - fstall = ireq_valid & ~iresp_data_ok
  - lu = ex_valid & ex_is_load & ex_dst!=0 & ((id_use1 & id_ra1==ex_dst) | (id_use2 & id_ra2==ex_dst))
- Priority: mstall > redirect > load-use > fstall. Default: all en=1, flush=0, pc_we=1, pc_sel=0.
- mstall:
  - pc_we=0; fd_en=de_en=em_en=0.
  - mw_en=1, mw_flush=1: bubble to WB.
  - The redirect stays asserted because EX is frozen; no latching.
- Redirect (ex_redirect & ex_valid, no mstall):
  - fd_flush=1, de_flush=1.
  - In F_NORM with iresp_data_ok=1: pc_we=1, pc_sel=1, pc_target=ex_target.
  - In F_NORM with iresp_data_ok=0: pc_we=0, pend_pc<=ex_target, next state F_DROP.
- Load-use (no mstall, no redirect):
  - pc_we=0, fd_en=0 (hold), de_flush=1 (bubble). EX/MEM/WB advance.
  - Exactly 1 bubble per hazard.
- fstall only: pc_we=0, fd_flush=1. Downstream advances.
- Both fstall and lu active: fd_en=0 takes precedence over fd_flush.
- F_DROP:
  - fd_flush=1 every cycle; pc_target=pend_pc.
  - On iresp_data_ok: pc_we=1, pc_sel=1, next state F_NORM (stale instruction discarded).
  - Until then: pc_we=0.
  - A new redirect in F_DROP overwrites pend_pc.
  - mstall in F_DROP: hold state; the drop completes when data_ok arrives, but pc_we stays 0 while mstall is active. Keep pend_pc until both conditions clear.
- Outputs are combinational from inputs and state. Only state, pend_pc and stall_cnt are registered.
- stall_cnt: +1 on every non-reset cycle with pc_we=0; wraps at 2^32.
- Reset mid-drop: returns to F_NORM, pend_pc cleared.

Decomposition:
- Shared package pipes: add pipe_ctl_t struct {en, flush} and fetch_state_t enum {F_NORM, F_DROP}.
- Optional sub-module hazard_detect (combinational lu calculation); the FSM stays in pipe_ctrl.

Test Plan:
- Load x5 in EX, decode uses rs1=x5 with id_use1=1 -> exactly 1 cycle of pc_we=0, fd_en=0, de_flush=1; next cycle normal.
- Same with ex_dst=0 -> no stall.
- ex_redirect=1, ex_target=0x80000100, iresp_data_ok=1 -> same cycle pc_we=1, pc_sel=1, pc_target=0x80000100, fd_flush=de_flush=1.
- ex_redirect with iresp_data_ok=0 for 3 cycles, then 1 -> pc_we=0 and fd_flush=1 for those 3 cycles; on the data_ok cycle pc_we=1, pc_target=0x80000100, state returns to F_NORM.
- dreq_valid=1, dresp_data_ok=0 for 4 cycles -> fd/de/em_en=0 and mw_flush=1 for 4 cycles; stall_cnt +4.
- mstall concurrent with redirect and load-use -> only the mstall response; redirect taken the cycle dresp_data_ok=1.
- Reset asserted in F_DROP -> next cycle F_NORM, pend_pc=0, stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: per-stage register control and
// the fetch-drop state encoding.
package pipe_ctrl_pkg;

    typedef struct packed {
        logic en;
        logic flush;
    } pipe_ctl_t;

    typedef enum logic {
        F_NORM = 1'b0,
        F_DROP = 1'b1
    } fetch_state_t;

    localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in decode.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [REG_W-1:0] i_ex_dst,
    input  logic [REG_W-1:0] i_id_ra1,
    input  logic [REG_W-1:0] i_id_ra2,
    input  logic             i_id_use1,
    input  logic             i_id_use2,
    output logic             o_lu
);

    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = i_id_use1 && (i_id_ra1 == i_ex_dst);
    assign w_hit2 = i_id_use2 && (i_id_ra2 == i_ex_dst);
    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign o_lu   = i_ex_valid && i_ex_is_load && (i_ex_dst != '0) && (w_hit1 || w_hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: PC update control,
// per-stage enable/flush, and the fetch-drop FSM for redirects mid-fetch.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq_valid,
    input  logic              iresp_data_ok,
    input  logic              dreq_valid,
    input  logic              dresp_data_ok,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_dst,
    input  logic [REG_W-1:0]  id_ra1,
    input  logic [REG_W-1:0]  id_ra2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_target,
    output logic              pc_we,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              fd_en,
    output logic              fd_flush,
    output logic              de_en,
    output logic              de_flush,
    output logic              em_en,
    output logic              em_flush,
    output logic              mw_en,
    output logic              mw_flush,
    output logic [31:0]       stall_cnt
);

    fetch_state_t            r_state;
    fetch_state_t            w_state_nxt;
    logic [ADDR_W-1:0]       r_pend_pc;
    logic [ADDR_W-1:0]       w_pend_nxt;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;

    logic w_mstall, w_fstall, w_lu, w_redir;
    logic w_pc_we, w_pc_sel;
    logic [ADDR_W-1:0] w_pc_target;
    pipe_ctl_t w_fd, w_de, w_em, w_mw;

    assign w_mstall = dreq_valid && !dresp_data_ok;
    assign w_fstall = ireq_valid && !iresp_data_ok;
    assign w_redir  = ex_redirect && ex_valid;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .i_ex_valid  (ex_valid),
        .i_ex_is_load(ex_is_load),
        .i_ex_dst    (ex_dst),
        .i_id_ra1    (id_ra1),
        .i_id_ra2    (id_ra2),
        .i_id_use1   (id_use1),
        .i_id_use2   (id_use2),
        .o_lu        (w_lu)
    );

    always_comb begin
        w_fd        = '{en: 1'b1, flush: 1'b0};
        w_de        = '{en: 1'b1, flush: 1'b0};
        w_em        = '{en: 1'b1, flush: 1'b0};
        w_mw        = '{en: 1'b1, flush: 1'b0};
        w_pc_we     = 1'b1;
        w_pc_sel    = 1'b0;
        w_pc_target = (r_state == F_DROP) ? r_pend_pc : ex_target;
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_pc;

        if (reset) begin
            w_fd        = '{en: 1'b1, flush: 1'b1};
            w_de        = '{en: 1'b1, flush: 1'b1};
            w_em        = '{en: 1'b1, flush: 1'b1};
            w_mw        = '{en: 1'b1, flush: 1'b1};
            w_pc_we     = 1'b0;
            w_pc_target = '0;
        end else if (w_mstall) begin
            // EX is frozen, so any redirect there simply re-presents later.
            w_pc_we     = 1'b0;
            w_fd.en     = 1'b0;
            w_de.en     = 1'b0;
            w_em.en     = 1'b0;
            w_mw.flush  = 1'b1;
            w_fd.flush  = (r_state == F_DROP);
        end else if (w_redir) begin
            w_fd.flush = 1'b1;
            w_de.flush = 1'b1;
            if (iresp_data_ok) begin
                w_pc_sel    = 1'b1;
                w_pc_target = ex_target;
                w_state_nxt = F_NORM;
            end else begin
                // Fetch still in flight: remember target, discard its response.
                w_pc_we     = 1'b0;
                w_pend_nxt  = ex_target;
                w_state_nxt = F_DROP;
            end
        end else if (r_state == F_DROP) begin
            w_fd.flush = 1'b1;
            if (w_lu) begin
                w_fd.en    = 1'b0;
                w_de.flush = 1'b1;
            end
            if (iresp_data_ok) begin
                w_pc_sel    = 1'b1;
                w_state_nxt = F_NORM;
            end else begin
                w_pc_we = 1'b0;
            end
        end else if (w_lu) begin
            w_pc_we    = 1'b0;
            w_fd.en    = 1'b0;
            w_de.flush = 1'b1;
        end else if (w_fstall) begin
            w_pc_we    = 1'b0;
            w_fd.flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= F_NORM;
            r_pend_pc   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_pc <= w_pend_nxt;
            if (!w_pc_we) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign pc_we     = w_pc_we;
    assign pc_sel    = w_pc_sel;
    assign pc_target = w_pc_target;
    assign fd_en     = w_fd.en;
    assign fd_flush  = w_fd.flush;
    assign de_en     = w_de.en;
    assign de_flush  = w_de.flush;
    assign em_en     = w_em.en;
    assign em_flush  = w_em.flush;
    assign mw_en     = w_mw.en;
    assign mw_flush  = w_mw.flush;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int ADDR_W = 64;
    localparam int REG_W  = 5;
    localparam logic [ADDR_W-1:0] TGT = 64'h0000_0000_8000_0100;
    // {fd_en,fd_flush,de_en,de_flush,em_en,em_flush,mw_en,mw_flush,pc_we,pc_sel}
    localparam logic [9:0] C_NORM = 10'b1010101010;
    localparam logic [9:0] C_RST  = 10'b1111111100;

    logic clk = 1'b0;
    logic reset;
    logic ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok;
    logic ex_valid, ex_is_load, id_use1, id_use2, ex_redirect;
    logic [REG_W-1:0] ex_dst, id_ra1, id_ra2;
    logic [ADDR_W-1:0] ex_target;
    logic pc_we, pc_sel;
    logic [ADDR_W-1:0] pc_target;
    logic fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush;
    logic [31:0] stall_cnt;
    logic [9:0] ctl;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign ctl = {fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush, pc_we, pc_sel};

    pipe_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .iresp_data_ok(iresp_data_ok),
        .dreq_valid(dreq_valid), .dresp_data_ok(dresp_data_ok),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dst(ex_dst),
        .id_ra1(id_ra1), .id_ra2(id_ra2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target),
        .fd_en(fd_en), .fd_flush(fd_flush), .de_en(de_en), .de_flush(de_flush),
        .em_en(em_en), .em_flush(em_flush), .mw_en(mw_en), .mw_flush(mw_flush),
        .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ireq_valid = 1'b1; iresp_data_ok = 1'b1;
        dreq_valid = 1'b0; dresp_data_ok = 1'b1;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_dst = '0;
        id_ra1 = '0; id_ra2 = '0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_redirect = 1'b0; ex_target = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        ex_target = TGT;
        #4;
        total++; if (ctl !== C_RST) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
        total++; if (pc_target !== '0) begin bad++; $display("FAIL reset_target got=%h exp=0", pc_target); end
        tick();
        tick();
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        reset = 1'b0;
        ex_target = '0;
    endtask

    task automatic test_load_use();
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dst = 5'd5; id_ra1 = 5'd5; id_use1 = 1'b1;
        #4;
        total++; if (ctl !== 10'b0011101000) begin bad++; $display("FAIL lu_ctl got=%b exp=%b", ctl, 10'b0011101000); end
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        #4;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL lu_after got=%b exp=%b", ctl, C_NORM); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        // rs2 path, with a concurrent fetch stall: hold wins over flush
        idle();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dst = 5'd7; id_ra2 = 5'd7; id_use2 = 1'b1;
        iresp_data_ok = 1'b0;
        #4;
        total++; if (ctl !== 10'b0011101000) begin bad++; $display("FAIL lu_rs2_ctl got=%b exp=%b", ctl, 10'b0011101000); end
        tick();
        idle();
    endtask

    task automatic test_load_use_x0();
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dst = 5'd0; id_ra1 = 5'd0; id_use1 = 1'b1;
        #4;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_NORM); end
        ex_dst = 5'd9; id_ra1 = 5'd9; id_use1 = 1'b0;
        #2;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL lu_nouse got=%b exp=%b", ctl, C_NORM); end
        tick();
        idle();
    endtask

    task automatic test_redirect_hit();
        do_reset();
        ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = TGT;
        #4;
        total++; if (ctl !== 10'b1111101011) begin bad++; $display("FAIL redir_ctl got=%b exp=%b", ctl, 10'b1111101011); end
        total++; if (pc_target !== TGT) begin bad++; $display("FAIL redir_target got=%h exp=%h", pc_target, TGT); end
        tick();
        idle();
        #4;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL redir_after got=%b exp=%b", ctl, C_NORM); end
    endtask

    task automatic test_redirect_deferred();
        do_reset();
        ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = TGT; iresp_data_ok = 1'b0;
        #4;
        total++; if (ctl !== 10'b1111101000) begin bad++; $display("FAIL defer_c1 got=%b exp=%b", ctl, 10'b1111101000); end
        for (int c = 0; c < 2; c++) begin
            tick();
            ex_valid = 1'b0; ex_redirect = 1'b0; ex_target = 64'h1234;
            #4;
            total++; if (ctl !== 10'b1110101000) begin bad++; $display("FAIL defer_wait%0d got=%b exp=%b", c, ctl, 10'b1110101000); end
            total++; if (pc_target !== TGT) begin bad++; $display("FAIL defer_pend%0d got=%h exp=%h", c, pc_target, TGT); end
        end
        tick();
        iresp_data_ok = 1'b1;
        #4;
        total++; if (ctl !== 10'b1110101011) begin bad++; $display("FAIL defer_done got=%b exp=%b", ctl, 10'b1110101011); end
        total++; if (pc_target !== TGT) begin bad++; $display("FAIL defer_target got=%h exp=%h", pc_target, TGT); end
        tick();
        #4;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL defer_norm got=%b exp=%b", ctl, C_NORM); end
        total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL defer_cnt got=%0d exp=3", stall_cnt); end
        idle();
    endtask

    task automatic test_mstall();
        do_reset();
        dreq_valid = 1'b1; dresp_data_ok = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #4;
            total++; if (ctl !== 10'b0000001100) begin bad++; $display("FAIL mstall_c%0d got=%b exp=%b", c, ctl, 10'b0000001100); end
            tick();
        end
        dresp_data_ok = 1'b1;
        #4;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL mstall_end got=%b exp=%b", ctl, C_NORM); end
        total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL mstall_cnt got=%0d exp=4", stall_cnt); end
        tick();
        idle();
    endtask

    task automatic test_mstall_priority();
        do_reset();
        dreq_valid = 1'b1; dresp_data_ok = 1'b0;
        ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = TGT;
        ex_is_load = 1'b1; ex_dst = 5'd5; id_ra1 = 5'd5; id_use1 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #4;
            total++; if (ctl !== 10'b0000001100) begin bad++; $display("FAIL prio_c%0d got=%b exp=%b", c, ctl, 10'b0000001100); end
            tick();
        end
        dresp_data_ok = 1'b1;
        #4;
        total++; if (ctl !== 10'b1111101011) begin bad++; $display("FAIL prio_redir got=%b exp=%b", ctl, 10'b1111101011); end
        total++; if (pc_target !== TGT) begin bad++; $display("FAIL prio_target got=%h exp=%h", pc_target, TGT); end
        tick();
        idle();
    endtask

    task automatic test_drop_mstall();
        do_reset();
        ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = TGT; iresp_data_ok = 1'b0;
        tick();
        idle();
        dreq_valid = 1'b1; dresp_data_ok = 1'b0; iresp_data_ok = 1'b1;
        #4;
        total++; if (ctl !== 10'b0100001100) begin bad++; $display("FAIL dropm_hold got=%b exp=%b", ctl, 10'b0100001100); end
        tick();
        dresp_data_ok = 1'b1;
        #4;
        total++; if (ctl !== 10'b1110101011) begin bad++; $display("FAIL dropm_done got=%b exp=%b", ctl, 10'b1110101011); end
        total++; if (pc_target !== TGT) begin bad++; $display("FAIL dropm_target got=%h exp=%h", pc_target, TGT); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_drop();
        do_reset();
        ex_valid = 1'b1; ex_redirect = 1'b1; ex_target = 64'hdead_0000; iresp_data_ok = 1'b0;
        tick();
        idle();
        iresp_data_ok = 1'b0;
        #4;
        total++; if (pc_target !== 64'hdead_0000) begin bad++; $display("FAIL rdrop_pend got=%h exp=%h", pc_target, 64'hdead_0000); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        iresp_data_ok = 1'b1;
        #4;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL rdrop_state got=%b exp=%b", ctl, C_NORM); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rdrop_cnt got=%0d exp=0", stall_cnt); end
        tick();
    endtask

    task automatic test_random();
        bit m_drop;
        logic [ADDR_W-1:0] m_pend;
        logic [31:0] m_cnt;
        bit freeze, redir, hazard, fstall, e_we, e_sel, e_fd_en, e_fd_fl, e_de_fl;
        logic [9:0] e_ctl;
        logic [ADDR_W-1:0] e_tgt;
        do_reset();
        m_drop = 1'b0; m_pend = '0; m_cnt = '0;
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(59) == 0);
            ireq_valid    = ($urandom_range(7) != 0);
            iresp_data_ok = ($urandom_range(2) != 0);
            dreq_valid    = ($urandom_range(3) == 0);
            dresp_data_ok = $urandom_range(1);
            ex_valid      = ($urandom_range(3) != 0);
            ex_is_load    = ($urandom_range(2) == 0);
            ex_dst        = REG_W'($urandom_range(3));
            id_ra1        = REG_W'($urandom_range(3));
            id_ra2        = REG_W'($urandom_range(3));
            id_use1       = $urandom_range(1);
            id_use2       = $urandom_range(1);
            ex_redirect   = ($urandom_range(5) == 0);
            ex_target     = {$urandom, $urandom};
            #4;
            if (reset) begin
                total++; if (ctl !== C_RST) begin bad++; $display("FAIL rnd_rst_ctl n=%0d got=%b exp=%b", n, ctl, C_RST); end
                m_drop = 1'b0; m_pend = '0; m_cnt = '0;
            end else begin
                freeze = dreq_valid && !dresp_data_ok;
                redir  = ex_redirect && ex_valid;
                hazard = ex_valid && ex_is_load && ex_dst != 0 &&
                         ((id_use1 && id_ra1 == ex_dst) || (id_use2 && id_ra2 == ex_dst));
                fstall = ireq_valid && !iresp_data_ok;
                // PC moves only when nothing upstream or downstream holds it back
                e_we    = !freeze && ((redir || m_drop) ? iresp_data_ok : (!hazard && !fstall));
                e_sel   = e_we && (redir || m_drop);
                e_fd_en = !freeze && !(hazard && !redir);
                e_fd_fl = m_drop || (!freeze && (redir || (!hazard && fstall)));
                e_de_fl = !freeze && (redir || hazard);
                e_ctl   = {e_fd_en, e_fd_fl, !freeze, e_de_fl, !freeze, 1'b0, 1'b1, freeze, e_we, e_sel};
                e_tgt   = redir ? ex_target : m_pend;
                total++; if (ctl !== e_ctl) begin bad++; $display("FAIL rnd_ctl n=%0d got=%b exp=%b", n, ctl, e_ctl); end
                if (e_sel) begin
                    total++; if (pc_target !== e_tgt) begin bad++; $display("FAIL rnd_target n=%0d got=%h exp=%h", n, pc_target, e_tgt); end
                end
                if (!freeze) begin
                    if (redir && !iresp_data_ok) begin
                        m_drop = 1'b1; m_pend = ex_target;
                    end else if ((redir || m_drop) && iresp_data_ok) begin
                        m_drop = 1'b0;
                    end
                end
                if (!e_we) m_cnt = m_cnt + 1;
            end
            tick();
            total++; if (stall_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_cnt); end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_load_use_x0();
        test_redirect_hit();
        test_redirect_deferred();
        test_mstall();
        test_mstall_priority();
        test_drop_mstall();
        test_reset_mid_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
